udp_tx_cmac_pkt_fifo: RTL
=========================

// Module: udp_tx_cmac_pkt_fifo
// PURPOSE
//  Store-and-forward packet FIFO between the UDP engine TX output and the CMAC TX AXI-Stream input.
//  The CMAC forbids tvalid gaps inside a frame, so a packet is released only once all its beats are stored.
//  Oversize packets are dropped whole. Short frames are optionally padded to the Ethernet minimum.
// PARAMETERS
//  DATA_WIDTH      512   stream data width, bits
//  KEEP_WIDTH      64    DATA_WIDTH/8
//  DEPTH           64    FIFO depth in beats; power of 2; must be >= MAX_PKT_BEATS
//  MAX_PKT_BEATS   24    largest accepted packet in beats; longer packets are dropped
//  MIN_FRAME_BYTES 60    minimum frame length (no FCS) used by padding
// PORTS
//  tx_axis_aclk     in   1                 clock
//  tx_axis_areset   in   1                 asynchronous reset, active-high
//  s_axis_tdata     in   DATA_WIDTH        packet data from the UDP engine (cmac_tx_axis_*)
//  s_axis_tkeep     in   KEEP_WIDTH        byte enables; contiguous from bit 0
//  s_axis_tvalid    in   1                 input valid
//  s_axis_tlast     in   1                 last beat of packet
//  s_axis_tready    out  1                 input ready
//  m_axis_tdata     out  DATA_WIDTH        to CMAC TX
//  m_axis_tkeep     out  KEEP_WIDTH
//  m_axis_tvalid    out  1
//  m_axis_tlast     out  1
//  m_axis_tready    in   1
//  stat_pkt_count   out  $clog2(DEPTH)+1   complete packets currently stored
//  stat_drop_count  out  32                oversize packets dropped; wraps modulo 2^32
// BEHAVIOUR
//  Reset values: s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, tdata/tkeep=0, both stats=0.
//  s_axis_tready is 1 from the first cycle after reset release while the FIFO is not full.
//  Write side keeps two pointers:
//  - wr_ptr: speculative; advances on every stored beat.
//  - commit_ptr: updated to wr_ptr+1 on the edge that accepts a tlast beat.
//  - stat_pkt_count increments on that same edge.
//  Full means wr_ptr - rd_ptr == DEPTH. Pointers are $clog2(DEPTH)+1 bits and wrap naturally.
//  Drop rule: a beat that would be beat number MAX_PKT_BEATS+1 of a packet is not stored.
//  - On that edge wr_ptr rolls back to commit_ptr.
//  - FSM enters DISCARD.
//  - In DISCARD: s_axis_tready=1 and beats are accepted and discarded.
//  - The tlast beat in DISCARD increments stat_drop_count and returns the FSM to IDLE.
//  Write FSM:
//  - IDLE: no packet open. First accepted beat -> ACTIVE, or stays IDLE if that beat has tlast.
//  - ACTIVE: accepted tlast -> IDLE; overflow beat -> DISCARD.
//  - DISCARD: accepted tlast -> IDLE.
//  Read side:
//  - A registered output stage loads a beat whenever rd_ptr != commit_ptr and the stage is empty or being drained.
//  - Tlast accepted at edge k gives m_axis_tvalid=1 after edge k+1, when the FIFO was empty.
//  - Once a packet starts, m_axis_tvalid stays high every cycle until its tlast handshake.
//  - The output holds stable while m_axis_tready=0.
//  - stat_pkt_count decrements on the m_axis tlast handshake.
//  Simultaneous commit and tlast read in one cycle: stat_pkt_count is unchanged.
//  Simultaneous write and read when full: the read frees a slot but tready is not raised in that same cycle.
//  Reset mid-packet: partial and stored packets are lost and all state returns to reset values.
//  - A CMAC frame cut by reset is the system's responsibility.
// CONFIGURATION
//  TX_MIN_FRAME_PAD_EN defined:
//  - Applies to an output beat that is the first beat of its packet and has tlast.
//  - If popcount(tkeep) < MIN_FRAME_BYTES, then m_axis_tkeep = MIN_FRAME_BYTES ones from bit 0.
//  - Bytes beyond the original tkeep are driven 0.
//  - Done in the output register; no added latency.
//  TX_MIN_FRAME_PAD_EN undefined:
//  - tkeep and tdata pass through unmodified; the CMAC is configured to pad.
// TESTING
//  - 3-beat pkt (tkeep all ones, last tkeep=0x0000_FFFF): output is 3 contiguous beats.
//    - Same data/keep; tvalid first high 2 cycles after the input tlast; pkt_count 1->0.
//  - Input stalls 5 cycles mid-packet: no m_axis_tvalid until tlast is stored, then no gaps.
//  - 25-beat packet, then 2-beat packet: 25-beat packet is dropped.
//    - stat_drop_count=1; only the 2-beat packet appears on output.
//  - m_axis_tready=0 with 64 single-beat packets written: s_axis_tready=0 at 64 stored.
//    - stat_pkt_count=64; releasing tready drains all 64 in order.
//  - Pad mode, 1-beat pkt tkeep=0x3FF (10 B): out tkeep=0x0FFF_FFFF_FFFF_FFFF.
//    - Bytes 10..59 = 0. Macro off: tkeep=0x3FF.
//  - Reset asserted mid-packet for 1 cycle: all outputs 0.
//    - Next full packet passes intact; stats=0 before it.

Source files
------------

// File: rtl/udp_tx_cmac_pkt_fifo.sv
// udp_tx_cmac_pkt_fifo
// Store-and-forward packet FIFO between the UDP engine TX stream and the
// CMAC TX AXI-Stream input. A packet is only released downstream once all of
// its beats are stored, so the CMAC never sees tvalid gaps inside a frame.
// Packets longer than MAX_PKT_BEATS are dropped whole.
//
// Build option:
//   TX_MIN_FRAME_PAD_EN  pad single-beat frames shorter than MIN_FRAME_BYTES
//                        in the output register (tkeep widened, new bytes 0).
//   undefined            tdata/tkeep pass through unmodified.

module udp_tx_cmac_pkt_fifo #(
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned KEEP_WIDTH      = 64,
  parameter int unsigned DEPTH           = 64,
  parameter int unsigned MAX_PKT_BEATS   = 24,
  parameter int unsigned MIN_FRAME_BYTES = 60
) (
  input  logic                      tx_axis_aclk,
  input  logic                      tx_axis_areset,

  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]     s_axis_tkeep,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_tready,

  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]     m_axis_tkeep,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready,

  output logic [$clog2(DEPTH):0]    stat_pkt_count,
  output logic [31:0]               stat_drop_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned BW = $clog2(MAX_PKT_BEATS + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACTIVE  = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  logic [1:0]            state;
  logic [BW-1:0]         pkt_beats;
  logic                  ready_q;

  // wr_ptr: speculative write position; commit_ptr: end of last complete packet.
  // fetch_ptr: next beat to load into the output register.
  // rd_ptr: oldest slot still owned (freed only on the output handshake),
  // so the beat sitting in the output register still counts as stored.
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         commit_ptr;
  logic [PW-1:0]         fetch_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr_nxt;
  logic [PW-1:0]         rd_ptr_nxt;

  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [KEEP_WIDTH-1:0] mem_keep [DEPTH];
  logic                  mem_last [DEPTH];

  logic                  in_fire;
  logic                  overflow;
  logic                  wr_store;
  logic                  commit;
  logic                  discard_end;
  logic                  out_fire;
  logic                  out_load;
  logic [AW-1:0]         fetch_idx;

  logic [DATA_WIDTH-1:0] load_data;
  logic [KEEP_WIDTH-1:0] load_keep;
  logic                  load_last;

`ifdef TX_MIN_FRAME_PAD_EN
  // Set when the next beat loaded into the output register opens a packet.
  logic                  first_q;

  function automatic int unsigned keep_count(input logic [KEEP_WIDTH-1:0] k);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
      n = n + int'(k[i]);
    end
    return n;
  endfunction
`endif

  // Handshake decode and next-pointer computation
  always_comb begin
    s_axis_tready = ready_q || (state == ST_DISCARD);
    in_fire       = s_axis_tvalid && s_axis_tready;
    overflow      = in_fire && (state != ST_DISCARD) &&
                    (pkt_beats == BW'(MAX_PKT_BEATS));
    wr_store      = in_fire && (state != ST_DISCARD) && !overflow;
    commit        = wr_store && s_axis_tlast;
    discard_end   = in_fire && s_axis_tlast &&
                    ((state == ST_DISCARD) || overflow);
    out_fire      = m_axis_tvalid && m_axis_tready;
    out_load      = (fetch_ptr != commit_ptr) && (!m_axis_tvalid || m_axis_tready);
    fetch_idx     = fetch_ptr[AW-1:0];

    wr_ptr_nxt = wr_ptr;
    if (overflow) begin
      wr_ptr_nxt = commit_ptr;
    end else if (wr_store) begin
      wr_ptr_nxt = wr_ptr + 1'b1;
    end
    rd_ptr_nxt = out_fire ? rd_ptr + 1'b1 : rd_ptr;
  end

  // Beat storage (no reset needed, validity is tracked by the pointers)
  always_ff @(posedge tx_axis_aclk) begin
    if (wr_store) begin
      mem_data[wr_ptr[AW-1:0]] <= s_axis_tdata;
      mem_keep[wr_ptr[AW-1:0]] <= s_axis_tkeep;
      mem_last[wr_ptr[AW-1:0]] <= s_axis_tlast;
    end
  end

  // Write-side FSM, pointers, ready and drop statistic
  always_ff @(posedge tx_axis_aclk or posedge tx_axis_areset) begin
    if (tx_axis_areset) begin
      state           <= ST_IDLE;
      pkt_beats       <= '0;
      wr_ptr          <= '0;
      commit_ptr      <= '0;
      ready_q         <= 1'b0;
      stat_drop_count <= '0;
    end else begin
      wr_ptr  <= wr_ptr_nxt;
      // Registered full flag: a read freeing a slot raises ready one cycle later.
      ready_q <= (wr_ptr_nxt - rd_ptr_nxt) != PW'(DEPTH);

      if (commit) begin
        commit_ptr <= wr_ptr + 1'b1;
      end

      if (overflow || commit) begin
        pkt_beats <= '0;
      end else if (wr_store) begin
        pkt_beats <= pkt_beats + 1'b1;
      end

      if (discard_end) begin
        stat_drop_count <= stat_drop_count + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (wr_store && !s_axis_tlast) begin
            state <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          // An overflow beat that is itself tlast closes the dropped packet at once.
          if (overflow) begin
            state <= s_axis_tlast ? ST_IDLE : ST_DISCARD;
          end else if (commit) begin
            state <= ST_IDLE;
          end
        end
        ST_DISCARD: begin
          if (in_fire && s_axis_tlast) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output-beat formation, including optional short-frame padding
  always_comb begin
    load_data = mem_data[fetch_idx];
    load_keep = mem_keep[fetch_idx];
    load_last = mem_last[fetch_idx];
`ifdef TX_MIN_FRAME_PAD_EN
    if (first_q && load_last && (keep_count(mem_keep[fetch_idx]) < MIN_FRAME_BYTES)) begin
      for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
        if (!mem_keep[fetch_idx][i]) begin
          load_data[i*8 +: 8] = '0;
        end
        load_keep[i] = (i < MIN_FRAME_BYTES);
      end
    end
`endif
  end

  // Registered output stage and read pointers
  always_ff @(posedge tx_axis_aclk or posedge tx_axis_areset) begin
    if (tx_axis_areset) begin
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      fetch_ptr     <= '0;
      rd_ptr        <= '0;
`ifdef TX_MIN_FRAME_PAD_EN
      first_q       <= 1'b1;
`endif
    end else begin
      rd_ptr <= rd_ptr_nxt;
      if (out_load) begin
        m_axis_tdata  <= load_data;
        m_axis_tkeep  <= load_keep;
        m_axis_tlast  <= load_last;
        m_axis_tvalid <= 1'b1;
        fetch_ptr     <= fetch_ptr + 1'b1;
`ifdef TX_MIN_FRAME_PAD_EN
        first_q       <= load_last;
`endif
      end else if (out_fire) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

  // Complete packets held: +1 on commit, -1 on output tlast handshake
  always_ff @(posedge tx_axis_aclk or posedge tx_axis_areset) begin
    if (tx_axis_areset) begin
      stat_pkt_count <= '0;
    end else begin
      case ({commit, out_fire && m_axis_tlast})
        2'b10:   stat_pkt_count <= stat_pkt_count + 1'b1;
        2'b01:   stat_pkt_count <= stat_pkt_count - 1'b1;
        default: stat_pkt_count <= stat_pkt_count;
      endcase
    end
  end

endmodule
